// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multicycle multiply/divide sequencer.
package multdiv_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned CNT_W      = $clog2(DEF_DATA_W);

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        RUN,
        FIX,
        DONE,
        DIVZ
    } state_t;

endpackage

// File: rtl/multdiv_step.sv
// One combinational iteration: shift-add multiply or restoring divide on magnitudes.
module multdiv_step
    import multdiv_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic [2*DATA_W-1:0] acc_in,
    input  logic [DATA_W-1:0]   opnd,
    input  logic                op,
    output logic [2*DATA_W-1:0] acc_out
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] rem_sh;
    logic [DATA_W:0] trial;

    always_comb begin
        // MULT: acc = {partial, multiplier}; carry of the add lands in the shifted-in top bit
        sum = {1'b0, acc_in[2*DATA_W-1:DATA_W]};
        if (acc_in[0]) begin
            sum = sum + {1'b0, opnd};
        end

        // DIV: acc = {remainder, dividend/quotient}; trial subtract on remainder shifted by one
        rem_sh = acc_in[2*DATA_W-1:DATA_W-1];
        trial  = rem_sh - {1'b0, opnd};

        if (op == OP_DIV) begin
            if (trial[DATA_W]) begin
                acc_out = {rem_sh[DATA_W-1:0], acc_in[DATA_W-2:0], 1'b0};
            end else begin
                acc_out = {trial[DATA_W-1:0], acc_in[DATA_W-2:0], 1'b1};
            end
        end else begin
            acc_out = {sum, acc_in[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_ctrl.sv
// Sequencer for the shared multicycle MULT/DIV unit; delivers HI/LO with strobes or a div0 pulse.
// Optional MULTDIV_UNSIGNED_EN adds op_unsigned for MULTU/DIVU.
module mult_div_ctrl
    import multdiv_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op_div,
`ifdef MULTDIV_UNSIGNED_EN
    input  logic              op_unsigned,
`endif
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic              busy,
    output logic              done,
    output logic              div0,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    output logic              hi_we,
    output logic              lo_we
);

    localparam int unsigned CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]       cnt;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] acc_step;
    logic [DATA_W-1:0]   opnd;
    logic                op_q;
    logic                sign_a;
    logic                sign_b;

    logic                uns;
    logic                sa_in;
    logic                sb_in;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;

    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quo;
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   res_hi;
    logic [DATA_W-1:0]   res_lo;

`ifdef MULTDIV_UNSIGNED_EN
    assign uns = op_unsigned;
`else
    assign uns = 1'b0;
`endif

    always_comb begin
        sa_in = a_in[DATA_W-1] & ~uns;
        sb_in = b_in[DATA_W-1] & ~uns;
        mag_a = sa_in ? ('0 - a_in) : a_in;
        mag_b = sb_in ? ('0 - b_in) : b_in;
    end

    multdiv_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .acc_in  (acc),
        .opnd    (opnd),
        .op      (op_q),
        .acc_out (acc_step)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        div0      = 1'b0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (op_q == OP_DIV && opnd == '0) begin
                    state_nxt = DIVZ;
                end else begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                hi_we     = 1'b1;
                lo_we     = 1'b1;
                state_nxt = IDLE;
            end
            DIVZ: begin
                div0      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Sign correction: quotient truncates toward zero, remainder follows the dividend
    always_comb begin
        prod = (sign_a ^ sign_b) ? ('0 - acc) : acc;
        quo  = acc[DATA_W-1:0];
        rem  = acc[2*DATA_W-1:DATA_W];
        if (op_q == OP_DIV) begin
            res_lo = (sign_a ^ sign_b) ? ('0 - quo) : quo;
            res_hi = sign_a ? ('0 - rem) : rem;
        end else begin
            res_hi = prod[2*DATA_W-1:DATA_W];
            res_lo = prod[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            op_q   <= OP_MULT;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            hi_out <= '0;
            lo_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= op_div;
                        sign_a <= sa_in;
                        sign_b <= sb_in;
                        if (op_div == OP_DIV) begin
                            acc  <= {{DATA_W{1'b0}}, mag_a};
                            opnd <= mag_b;
                        end else begin
                            acc  <= {{DATA_W{1'b0}}, mag_b};
                            opnd <= mag_a;
                        end
                    end
                end
                CHECK: begin
                    cnt <= '0;
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    hi_out <= res_hi;
                    lo_out <= res_lo;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed self-checking bench for mult_div_ctrl with hand-computed results.
module tb_mult_div_ctrl;

    localparam int unsigned W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic         op_div;
`ifdef MULTDIV_UNSIGNED_EN
    logic         op_unsigned;
`endif
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic         div0;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;
    logic         hi_we;
    logic         lo_we;

    int n_checks = 0;
    int n_pass   = 0;
    int c_done   = 0;
    int c_div0   = 0;
    int c_hiwe   = 0;
    int c_lowe   = 0;

    mult_div_ctrl #(
        .DATA_W (W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op_div (op_div),
`ifdef MULTDIV_UNSIGNED_EN
        .op_unsigned (op_unsigned),
`endif
        .a_in   (a_in),
        .b_in   (b_in),
        .busy   (busy),
        .done   (done),
        .div0   (div0),
        .hi_out (hi_out),
        .lo_out (lo_out),
        .hi_we  (hi_we),
        .lo_we  (lo_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done)  c_done++;
        if (div0)  c_div0++;
        if (hi_we) c_hiwe++;
        if (lo_we) c_lowe++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Issues a request at the next edge (E0); leaves time at E0+#1 with start dropped
    task automatic issue(input logic d, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start  = 1'b1;
        op_div = d;
        a_in   = a;
        b_in   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
    endtask

    // Counts further edges until done or div0 is seen; 999 on timeout
    task automatic wait_result(output int k);
        k = 0;
        while (!(done || div0) && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!(done || div0)) k = 999;
    endtask

    task automatic run_op(input string tag, input logic d, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
        int k, d0, dv;
        d0 = c_done;
        dv = c_div0;
        issue(d, a, b);
        wait_result(k);
        check({tag, " latency"}, 64'(k), 64'd34);
        check({tag, " hi"}, 64'(hi_out), 64'(ehi));
        check({tag, " lo"}, 64'(lo_out), 64'(elo));
        @(posedge clk);
        #1;
        check({tag, " busy after"}, 64'(busy), 64'd0);
        check({tag, " done pulses"}, 64'(c_done - d0), 64'd1);
        check({tag, " div0 pulses"}, 64'(c_div0 - dv), 64'd0);
    endtask

    initial begin
        int k, d0, h0, l0, v0;
        reset  = 1'b1;
        start  = 1'b0;
        op_div = 1'b0;
`ifdef MULTDIV_UNSIGNED_EN
        op_unsigned = 1'b0;
`endif
        a_in   = '0;
        b_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset strobes", 64'({done, div0, hi_we, lo_we}), 64'd0);
        check("reset hi", 64'(hi_out), 64'd0);
        check("reset lo", 64'(lo_out), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // MULT 7 * -3 with strobe accounting
        d0 = c_done; h0 = c_hiwe; l0 = c_lowe;
        issue(1'b0, 32'd7, 32'hFFFF_FFFD);
        check("mult busy", 64'(busy), 64'd1);
        wait_result(k);
        check("mult latency", 64'(k), 64'd34);
        check("mult strobes at done", 64'({hi_we, lo_we}), 64'b11);
        check("mult hi", 64'(hi_out), 64'hFFFF_FFFF);
        check("mult lo", 64'(lo_out), 64'hFFFF_FFEB);
        @(posedge clk);
        #1;
        check("mult busy after", 64'(busy), 64'd0);
        check("mult done after", 64'(done), 64'd0);
        check("mult done pulses", 64'(c_done - d0), 64'd1);
        check("mult hi_we pulses", 64'(c_hiwe - h0), 64'd1);
        check("mult lo_we pulses", 64'(c_lowe - l0), 64'd1);

        run_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // DIV by zero keeps previous outputs
        d0 = c_done; h0 = c_hiwe; v0 = c_div0;
        issue(1'b1, 32'd100, 32'd0);
        wait_result(k);
        check("div0 latency", 64'(k), 64'd1);
        check("div0 level", 64'(div0), 64'd1);
        @(posedge clk);
        #1;
        check("div0 busy after", 64'(busy), 64'd0);
        check("div0 pulses", 64'(c_div0 - v0), 64'd1);
        check("div0 no done", 64'(c_done - d0), 64'd0);
        check("div0 no we", 64'(c_hiwe - h0), 64'd0);
        check("div0 hi held", 64'(hi_out), 64'hFFFF_FFFF);
        check("div0 lo held", 64'(lo_out), 64'hFFFF_FFFD);

        run_op("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_op("mult min*min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
        run_op("div 100/-7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2);
        run_op("mult -1*-1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);

        // Second start during RUN iteration 5 is ignored
        d0 = c_done;
        issue(1'b0, 32'd123, 32'hFFFF_FFFB);
        repeat (5) @(posedge clk);
        @(negedge clk);
        start  = 1'b1;
        op_div = 1'b1;
        a_in   = 32'd100;
        b_in   = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_result(k);
        check("ignore latency", 64'(k + 6), 64'd34);
        check("ignore hi", 64'(hi_out), 64'hFFFF_FFFF);
        check("ignore lo", 64'(lo_out), 64'hFFFF_FD99);
        repeat (40) @(posedge clk);
        #1;
        check("ignore single done", 64'(c_done - d0), 64'd1);

        // Reset at RUN iteration 10 aborts
        d0 = c_done; h0 = c_hiwe;
        issue(1'b0, 32'd5, 32'd6);
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort hi", 64'(hi_out), 64'd0);
        check("abort lo", 64'(lo_out), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("abort no done", 64'(c_done - d0), 64'd0);
        check("abort no we", 64'(c_hiwe - h0), 64'd0);
        run_op("after reset 5*6", 1'b0, 32'd5, 32'd6, 32'd0, 32'd30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_div_ctrl.md
Name: mult_div_ctrl

Overview:
Sequencer for the shared multicycle multiply/divide resource behind the MULT and DIV R-format instructions.
- Accepts a one-cycle start from the main control FSM with operands taken from the A/B registers.
- Runs a DATA_W-iteration shift-add multiply or restoring divide.
- Delivers HI/LO with write strobes and a done pulse, or a div0 exception pulse.
- The main FSM holds in its MULT/DIV state until done or div0.

Parameters:
DATA_W, 32, operand width; HI/LO width; iteration count.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle request; sampled only in IDLE
op_div  in  1  0 = MULT, 1 = DIV; sampled with start
a_in  in  DATA_W  operand A (multiplicand / dividend)
b_in  in  DATA_W  operand B (multiplier / divisor)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse, result valid
div0  out  1  one-cycle pulse, DIV with b_in = 0
hi_out  out  DATA_W  product upper half / remainder
lo_out  out  DATA_W  product lower half / quotient
hi_we  out  1  HI write strobe, coincident with done
lo_we  out  1  LO write strobe, coincident with done

Behaviour:
- Reset values:
  - state = IDLE, busy = 0, done = 0, div0 = 0, hi_we = 0, lo_we = 0.
  - hi_out = 0, lo_out = 0, iteration counter = 0.
  - Reset overrides everything, including mid-operation: abort, no strobes, back to IDLE on the next edge.
- States: IDLE, CHECK, RUN, FIX, DONE, DIVZ.
- IDLE:
  - On start = 1 at edge E0, latch op_div, the operand magnitudes and the operand signs, then go to CHECK.
  - start while busy is ignored. It is not queued.
- CHECK (edge E0+1):
  - If op_div = 1 and the latched divisor is 0, go to DIVZ.
  - Otherwise clear the counter and go to RUN.
- RUN:
  - One iteration per cycle for DATA_W cycles, counter 0 to DATA_W-1.
  - Go to FIX on the edge after counter = DATA_W-1, i.e. at E0+DATA_W+1.
  - MULT: unsigned shift-add on magnitudes into a 2*DATA_W accumulator.
  - DIV: restoring divide on magnitudes, giving an unsigned quotient and remainder.
- FIX (one cycle): apply two's-complement sign correction, then register hi_out/lo_out.
  - MULT: negate the 2*DATA_W product if the operand signs differ. HI = upper half, LO = lower half.
  - DIV: quotient negated if the signs differ (truncation toward zero); remainder takes the dividend's sign.
  - Results are truncated to DATA_W. Most-negative / -1 gives LO = 0x80000000, HI = 0, with no exception.
- DONE (cycle E0+DATA_W+2 to E0+DATA_W+3):
  - done = hi_we = lo_we = 1 for exactly one cycle, then IDLE.
  - Total latency for DATA_W = 32: start edge to done-high is 34 edges.
- DIVZ (cycle E0+1 to E0+2):
  - div0 = 1 for one cycle, then IDLE.
  - hi_out/lo_out keep their previous values. No strobes.
- Output hold: hi_out/lo_out hold their last result in IDLE until the next FIX.
- Combinational from state only (Moore): busy, done, div0 and the strobes.
- Operand changes after the start edge have no effect.

Optional Feature:
MULTDIV_UNSIGNED_EN
- Defined:
  - Adds input op_unsigned (1 bit), sampled with start, for MULTU/DIVU.
  - When op_unsigned = 1, sign capture is forced positive and FIX applies no correction.
  - Latency is unchanged.
- Undefined: the port is absent and all operations are signed.

Decomposition:
- Package multdiv_pkg:
  - state enum (IDLE, CHECK, RUN, FIX, DONE, DIVZ).
  - DATA_W default.
  - CNT_W = clog2(DATA_W).
  - Op encoding constants OP_MULT = 0, OP_DIV = 1.
- One sub-module, multdiv_step: combinational single iteration.
  - MULT: conditional add and shift.
  - DIV: trial subtract and restore.
  - Inputs: accumulator, operand, op. Output: next accumulator.
  - Instantiated once inside mult_div_ctrl.

Test Plan:
- MULT a = 7, b = 0xFFFFFFFD (-3) -> done 34 edges after start; HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; hi_we = lo_we = 1 for exactly one cycle; busy low the cycle after.
- DIV a = 0xFFFFFFF9 (-7), b = 2 -> LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1); div0 never high.
- DIV a = 100, b = 0 -> div0 high one cycle at E0+1 to E0+2; no done/hi_we/lo_we; hi_out/lo_out unchanged from the prior result; busy low at E0+2.
- DIV a = 0x80000000, b = 0xFFFFFFFF -> LO = 0x80000000, HI = 0; no div0. MULT 0x80000000 × 0x80000000 -> HI = 0x40000000, LO = 0.
- Start MULT, pulse start again with DIV operands at RUN iteration 5 -> second request ignored; result is the MULT product.
- Assert reset at RUN iteration 10 -> IDLE next edge; busy = 0; no done/strobes; hi_out = lo_out = 0. A new start after reset completes normally.
